// File: rtl/serial_deser_if.sv
// Output-side bundle of serial_deser: the holding-register word, its
// valid/ready handshake and the overflow indication.
interface serial_deser_if #(
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] m_data_o;
  logic                  m_valid_o;
  logic                  m_ready_i;
  logic                  overflow_o;

  modport master (
    output m_data_o,
    output m_valid_o,
    output overflow_o,
    input  m_ready_i
  );

  modport slave (
    input  m_data_o,
    input  m_valid_o,
    input  overflow_o,
    output m_ready_i
  );
endinterface

// File: rtl/serial_deser.sv
// serial_deser: rebuilds DATA_WIDTH-bit words from a strobed one-bit serial
// stream and offers them through a one-word valid/ready holding register.
// DO_MSB_FIRST selects whether the first received bit lands in the word MSB
// ("TRUE") or LSB ("FALSE").
// Optional feature: define SERIAL_DESER_OVERFLOW_EN to get a sticky
// overflow_o flag that is set when a completed word is dropped and cleared
// by sync_i or reset. Without it overflow_o is constant 0.
module serial_deser #(
  parameter int    DATA_WIDTH   = 16,
  parameter string DO_MSB_FIRST = "TRUE"
) (
  input  logic            clk_i,
  input  logic            a_rst_n_i,
  input  logic            enable_i,
  input  logic            sync_i,
  input  logic            serial_data_i,
  serial_deser_if.master  m_if
);

  localparam int               CNT_W     = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DATA_WIDTH - 1);
  localparam bit               MSB_FIRST = (DO_MSB_FIRST == "TRUE");

  typedef enum logic {
    IDLE,
    RECV
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  complete;
  logic                  hold_free;

  // Push one bit into a word image in the configured bit order.
  function automatic logic [DATA_WIDTH-1:0] shift_in(
    input logic [DATA_WIDTH-1:0] base,
    input logic                  bit_in
  );
    if (MSB_FIRST) begin
      return {base[DATA_WIDTH-2:0], bit_in};
    end else begin
      return {bit_in, base[DATA_WIDTH-1:1]};
    end
  endfunction

  // Next-state logic: accumulation, word completion and holding-register load.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    valid_d   = valid_q;
    complete  = 1'b0;
    hold_free = !valid_q || m_if.m_ready_i;

    if (sync_i) begin
      if (enable_i) begin
        acc_d = shift_in('0, serial_data_i);
        cnt_d = CNT_W'(1);
      end else begin
        acc_d = '0;
        cnt_d = '0;
      end
    end else if (enable_i) begin
      acc_d = shift_in(acc_q, serial_data_i);
      if (cnt_q == CNT_LAST) begin
        complete = 1'b1;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    unique case (state_q)
      IDLE: begin
        if (enable_i) begin
          state_d = RECV;
        end
      end
      RECV: begin
        if (sync_i && !enable_i) begin
          state_d = IDLE;
        end else if (complete) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (valid_q && m_if.m_ready_i) begin
      valid_d = 1'b0;
    end
    if (complete && hold_free) begin
      data_d  = acc_d;
      valid_d = 1'b1;
    end
  end

  // State, accumulator and holding-register storage.
  always_ff @(posedge clk_i or negedge a_rst_n_i) begin
    if (!a_rst_n_i) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign m_if.m_data_o  = data_q;
  assign m_if.m_valid_o = valid_q;

`ifdef SERIAL_DESER_OVERFLOW_EN
  logic overflow_q;
  logic overflow_evt;

  assign overflow_evt = complete && !hold_free;

  // Sticky drop flag; a resync clears it even if a drop happens on that edge.
  always_ff @(posedge clk_i or negedge a_rst_n_i) begin
    if (!a_rst_n_i) begin
      overflow_q <= 1'b0;
    end else if (sync_i) begin
      overflow_q <= 1'b0;
    end else if (overflow_evt) begin
      overflow_q <= 1'b1;
    end
  end

  assign m_if.overflow_o = overflow_q;
`else
  assign m_if.overflow_o = 1'b0;
`endif

endmodule

// File: tb/tb_serial_deser.sv
// Testbench for serial_deser: an MSB-first and an LSB-first 8-bit instance
// share one serial stream; a reference model pushes expected words into
// scoreboard queues and accepted DUT words are popped and compared.
module tb_serial_deser;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstN;
  logic enable;
  logic syncIn;
  logic serialBit;
  logic readyLevel;

  serial_deser_if #(.DATA_WIDTH(8)) msbIf ();
  serial_deser_if #(.DATA_WIDTH(8)) lsbIf ();

  assign msbIf.m_ready_i = readyLevel;
  assign lsbIf.m_ready_i = readyLevel;

  serial_deser #(.DATA_WIDTH(8), .DO_MSB_FIRST("TRUE")) u_msb (
    .clk_i        (clk),
    .a_rst_n_i    (rstN),
    .enable_i     (enable),
    .sync_i       (syncIn),
    .serial_data_i(serialBit),
    .m_if         (msbIf)
  );

  serial_deser #(.DATA_WIDTH(8), .DO_MSB_FIRST("FALSE")) u_lsb (
    .clk_i        (clk),
    .a_rst_n_i    (rstN),
    .enable_i     (enable),
    .sync_i       (syncIn),
    .serial_data_i(serialBit),
    .m_if         (lsbIf)
  );

  int compared   = 0;
  int mismatched = 0;

  logic [7:0] expMsbQ[$];
  logic [7:0] expLsbQ[$];

  int         mCnt;
  logic [7:0] mMsbAcc;
  logic [7:0] mLsbAcc;
  logic       mValid;
  logic       mOvf;

  // Single comparison point: counts and reports every check.
  task automatic checkOutput(input string tag, input logic [15:0] actual,
                             input logic [15:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Reference model back to its reset state; held and partial words are lost.
  task automatic resetModel();
    mCnt    = 0;
    mMsbAcc = '0;
    mLsbAcc = '0;
    mValid  = 1'b0;
    mOvf    = 1'b0;
    expMsbQ.delete();
    expLsbQ.delete();
  endtask

  // All outputs of both instances must read zero.
  task automatic checkZeroOutputs(input string tag);
    checkOutput({tag, "MsbData"},  16'(msbIf.m_data_o),   16'h0);
    checkOutput({tag, "MsbValid"}, 16'(msbIf.m_valid_o),  16'h0);
    checkOutput({tag, "MsbOvf"},   16'(msbIf.overflow_o), 16'h0);
    checkOutput({tag, "LsbData"},  16'(lsbIf.m_data_o),   16'h0);
    checkOutput({tag, "LsbValid"}, 16'(lsbIf.m_valid_o),  16'h0);
    checkOutput({tag, "LsbOvf"},   16'(lsbIf.overflow_o), 16'h0);
  endtask

  // One clock of stimulus: drive, score any accepted word, advance model, check.
  task automatic applyStimulus(input logic en, input logic sy, input logic b);
    logic free;
    logic complete;
    @(negedge clk);
    enable    = en;
    syncIn    = sy;
    serialBit = b;
    #1;
    if (msbIf.m_valid_o && readyLevel) begin
      if (expMsbQ.size() > 0) begin
        checkOutput("msbWord", 16'(msbIf.m_data_o), 16'(expMsbQ.pop_front()));
      end else begin
        checkOutput("msbUnexpectedWord", 16'(expMsbQ.size()), 16'd1);
      end
    end
    if (lsbIf.m_valid_o && readyLevel) begin
      if (expLsbQ.size() > 0) begin
        checkOutput("lsbWord", 16'(lsbIf.m_data_o), 16'(expLsbQ.pop_front()));
      end else begin
        checkOutput("lsbUnexpectedWord", 16'(expLsbQ.size()), 16'd1);
      end
    end

    free     = !mValid || readyLevel;
    complete = 1'b0;
    if (sy) begin
      mCnt    = en ? 1 : 0;
      mMsbAcc = en ? {7'b0, b} : 8'h00;
      mLsbAcc = en ? {b, 7'b0} : 8'h00;
    end else if (en) begin
      mMsbAcc = {mMsbAcc[6:0], b};
      mLsbAcc = {b, mLsbAcc[7:1]};
      mCnt++;
      if (mCnt == 8) begin
        mCnt     = 0;
        complete = 1'b1;
      end
    end
    if (mValid && readyLevel) mValid = 1'b0;
    if (complete) begin
      if (free) begin
        mValid = 1'b1;
        expMsbQ.push_back(mMsbAcc);
        expLsbQ.push_back(mLsbAcc);
      end else begin
`ifdef SERIAL_DESER_OVERFLOW_EN
        mOvf = 1'b1;
`endif
      end
    end
    if (sy) mOvf = 1'b0;

    @(posedge clk);
    #1;
    checkOutput("msbValid", 16'(msbIf.m_valid_o),  16'(mValid));
    checkOutput("lsbValid", 16'(lsbIf.m_valid_o),  16'(mValid));
    checkOutput("msbOvf",   16'(msbIf.overflow_o), 16'(mOvf));
    checkOutput("lsbOvf",   16'(lsbIf.overflow_o), 16'(mOvf));
  endtask

  // Eight consecutive enables carrying a word MSB-first on the wire.
  task automatic sendWord(input logic [7:0] w, input logic syncFirst);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, syncFirst && (i == 0), w[7-i]);
    end
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0);
  endtask

  // Directed test-plan sequence followed by a short random run and a drain.
  initial begin
    logic ovfExpected;
`ifdef SERIAL_DESER_OVERFLOW_EN
    ovfExpected = 1'b1;
`else
    ovfExpected = 1'b0;
`endif
    rstN       = 1'b0;
    enable     = 1'b0;
    syncIn     = 1'b0;
    serialBit  = 1'b0;
    readyLevel = 1'b1;
    resetModel();
    #2;
    checkZeroOutputs("reset");
    #10;
    rstN = 1'b1;

    $display("[TB] MSB-first word without backpressure");
    sendWord(8'hA5, 1'b0);
    checkOutput("tp1Data", 16'(msbIf.m_data_o), 16'h00A5);
    idleCycles(2);

    $display("[TB] bit order");
    sendWord(8'hC0, 1'b0);
    checkOutput("tp2Msb", 16'(msbIf.m_data_o), 16'h00C0);
    checkOutput("tp2Lsb", 16'(lsbIf.m_data_o), 16'h0003);
    idleCycles(2);

    $display("[TB] backpressure and overflow");
    readyLevel = 1'b0;
    sendWord(8'h12, 1'b0);
    sendWord(8'h34, 1'b0);
    checkOutput("tp3Hold", 16'(msbIf.m_data_o),   16'h0012);
    checkOutput("tp3Ovf",  16'(msbIf.overflow_o), 16'(ovfExpected));
    idleCycles(2);
    checkOutput("tp3Stable", 16'(msbIf.m_data_o), 16'h0012);
    readyLevel = 1'b1;
    idleCycles(1);
    checkOutput("tp3Released", 16'(msbIf.m_valid_o),  16'h0);
    checkOutput("tp3OvfKept",  16'(msbIf.overflow_o), 16'(ovfExpected));

    $display("[TB] back-to-back words with accept on completion");
    sendWord(8'h11, 1'b0);
    sendWord(8'h22, 1'b0);
    sendWord(8'h33, 1'b0);
    idleCycles(2);

    $display("[TB] sync mid-word");
    applyStimulus(1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    sendWord(8'h5A, 1'b1);
    checkOutput("tp5Data", 16'(msbIf.m_data_o),   16'h005A);
    checkOutput("tp5Ovf",  16'(msbIf.overflow_o), 16'h0);
    idleCycles(2);

    $display("[TB] async reset mid-word");
    readyLevel = 1'b0;
    sendWord(8'h77, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 1'b1);
    enable = 1'b0;
    #1;
    rstN = 1'b0;
    #1;
    checkZeroOutputs("asyncReset");
    resetModel();
    #1;
    rstN = 1'b1;
    readyLevel = 1'b1;
    sendWord(8'hFF, 1'b0);
    checkOutput("tp6Data", 16'(msbIf.m_data_o), 16'h00FF);
    idleCycles(2);

    $display("[TB] random stream");
    for (int i = 0; i < 200; i++) begin
      readyLevel = 1'($urandom_range(0, 3) != 0);
      applyStimulus(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 31) == 0),
                    1'($urandom_range(0, 1)));
    end

    readyLevel = 1'b1;
    idleCycles(3);
    checkOutput("leftoverMsb", 16'(expMsbQ.size()), 16'd0);
    checkOutput("leftoverLsb", 16'(expLsbQ.size()), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
